// File: rtl/wb_retire_unit_pkg.sv
// Shared writeback constants, the retire entry layout and a busy-mask helper.
package wb_retire_unit_pkg;

    localparam int unsigned REG_NUM_W = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REGS  = 1 << REG_NUM_W;

    localparam logic [REG_NUM_W-1:0] REG_PC = 4'd15;

    // One pending retirement; packed width 70.
    typedef struct packed {
        logic [REG_NUM_W-1:0] rd_num;
        logic                 rd_en;
        logic [DATA_W-1:0]    data;
        logic                 cpsr_en;
        logic [DATA_W-1:0]    cpsr;
    } wb_entry_t;

    // One-hot register bit, or nothing when the entry does not write rd.
    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic                 en,
        input logic [REG_NUM_W-1:0] num
    );
        return en ? (NUM_REGS'(1) << num) : '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular retire queue: up to two pushes and one pop per cycle, with a
// per-entry rd fan-out so the top can build the pending-write mask.
module wb_fifo
    import wb_retire_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_push0,
    input  wb_entry_t                           i_push0_data,
    input  logic                                i_push1,
    input  wb_entry_t                           i_push1_data,
    input  logic                                i_pop,
    output logic [CNT_W-1:0]                    o_count,
    output wb_entry_t                           o_head,
    output logic [DEPTH-1:0]                    o_keep,
    output logic [DEPTH-1:0]                    o_ent_rd_en,
    output logic [DEPTH-1:0][REG_NUM_W-1:0]     o_ent_rd_num
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   w_tail_p1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_tail_p1 = ptr_inc(r_tail);

    // Pointer and occupancy update; a second push always follows the first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_pop) begin
                r_head <= ptr_inc(r_head);
            end
            if (i_push0 && i_push1) begin
                r_tail <= ptr_inc(w_tail_p1);
            end else if (i_push0) begin
                r_tail <= w_tail_p1;
            end
            r_count <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (i_push0) begin
            r_mem[r_tail] <= i_push0_data;
        end
        if (i_push1) begin
            r_mem[w_tail_p1] <= i_push1_data;
        end
    end

    // Entries still queued after this cycle's pop.
    always_comb begin
        logic [PTR_W-1:0] p;
        o_keep = '0;
        p      = r_head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) && !(i_pop && (k == 0))) begin
                o_keep[p] = 1'b1;
            end
            p = ptr_inc(p);
        end
    end

    // Per-entry destination fan-out.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_ent_rd_en[i]  = r_mem[i].rd_en;
            o_ent_rd_num[i] = r_mem[i].rd_num;
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/wb_retire_unit.sv
// Writeback retire unit: accepts EXE/MEM results, retires one per cycle onto
// the register file write port, and publishes a pending-write busy mask.
module wb_retire_unit
    import wb_retire_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 exe_valid,
    output logic                 exe_ready,
    input  logic [REG_NUM_W-1:0] exe_rd_num,
    input  logic                 exe_rd_en,
    input  logic [DATA_W-1:0]    exe_result,
    input  logic                 exe_cpsr_en,
    input  logic [DATA_W-1:0]    exe_cpsr,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [REG_NUM_W-1:0] mem_rd_num,
    input  logic [DATA_W-1:0]    mem_data,
    output logic [REG_NUM_W-1:0] wb_rd_num,
    output logic                 wb_rd_write_en,
    output logic [DATA_W-1:0]    wb_rd_in,
    output logic                 wb_cpsr_write_en,
    output logic [DATA_W-1:0]    wb_cpsr_in,
    output logic                 wb_branch_en,
    output logic [DATA_W-1:0]    wb_branch_target,
    output logic [NUM_REGS-1:0]  busy_mask
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t                          w_mem_ent;
    wb_entry_t                          w_exe_ent;
    wb_entry_t                          w_head;
    wb_entry_t                          w_out_ent;
    wb_entry_t                          w_push0_ent;
    wb_entry_t                          w_push1_ent;
    logic [CNT_W-1:0]                   w_count;
    logic                               w_ready;
    logic                               w_mem_acc;
    logic                               w_exe_acc;
    logic                               w_pop;
    logic                               w_out_v;
    logic                               w_push0;
    logic                               w_push1;
    logic [DEPTH-1:0]                   w_keep;
    logic [DEPTH-1:0]                   w_ent_rd_en;
    logic [DEPTH-1:0][REG_NUM_W-1:0]    w_ent_rd_num;
    logic [NUM_REGS-1:0]                w_busy_next;

    logic [REG_NUM_W-1:0]               r_wb_rd_num;
    logic                               r_wb_rd_write_en;
    logic [DATA_W-1:0]                  r_wb_rd_in;
    logic                               r_wb_cpsr_write_en;
    logic [DATA_W-1:0]                  r_wb_cpsr_in;
    logic                               r_wb_branch_en;
    logic [NUM_REGS-1:0]                r_busy_mask;

    // Room for two pushes is guaranteed whenever ready is high.
    assign w_ready   = reset && (w_count <= CNT_W'(DEPTH - 2));
    assign w_mem_acc = mem_valid && w_ready;
    assign w_exe_acc = exe_valid && w_ready;
    assign w_pop     = (w_count != '0);

    assign w_mem_ent = '{rd_num: mem_rd_num, rd_en: 1'b1, data: mem_data,
                         cpsr_en: 1'b0, cpsr: '0};
    assign w_exe_ent = '{rd_num: exe_rd_num, rd_en: exe_rd_en, data: exe_result,
                         cpsr_en: exe_cpsr_en, cpsr: exe_cpsr};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push0      (w_push0),
        .i_push0_data (w_push0_ent),
        .i_push1      (w_push1),
        .i_push1_data (w_push1_ent),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head       (w_head),
        .o_keep       (w_keep),
        .o_ent_rd_en  (w_ent_rd_en),
        .o_ent_rd_num (w_ent_rd_num)
    );

    // Retire source select (head, else bypass, else bubble) and in-order pushes, MEM first.
    always_comb begin
        w_out_v     = 1'b0;
        w_out_ent   = w_head;
        w_push0     = 1'b0;
        w_push0_ent = w_mem_ent;
        w_push1     = 1'b0;
        w_push1_ent = w_exe_ent;
        if (w_pop) begin
            w_out_v     = 1'b1;
            w_push0     = w_mem_acc || w_exe_acc;
            w_push0_ent = w_mem_acc ? w_mem_ent : w_exe_ent;
            w_push1     = w_mem_acc && w_exe_acc;
        end else if (w_mem_acc) begin
            w_out_v     = 1'b1;
            w_out_ent   = w_mem_ent;
            w_push0     = w_exe_acc;
            w_push0_ent = w_exe_ent;
        end else if (w_exe_acc) begin
            w_out_v     = 1'b1;
            w_out_ent   = w_exe_ent;
        end
    end

    // Pending writes after the edge: surviving queue entries, new pushes and the retiring entry.
    always_comb begin
        w_busy_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_keep[i]) begin
                w_busy_next |= reg_onehot(w_ent_rd_en[i], w_ent_rd_num[i]);
            end
        end
        if (w_push0) begin
            w_busy_next |= reg_onehot(w_push0_ent.rd_en, w_push0_ent.rd_num);
        end
        if (w_push1) begin
            w_busy_next |= reg_onehot(w_push1_ent.rd_en, w_push1_ent.rd_num);
        end
        if (w_out_v) begin
            w_busy_next |= reg_onehot(w_out_ent.rd_en, w_out_ent.rd_num);
        end
    end

    // Output register; data fields hold their last value on bubbles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wb_rd_num        <= '0;
            r_wb_rd_write_en   <= 1'b0;
            r_wb_rd_in         <= '0;
            r_wb_cpsr_write_en <= 1'b0;
            r_wb_cpsr_in       <= '0;
            r_wb_branch_en     <= 1'b0;
            r_busy_mask        <= '0;
        end else begin
            r_wb_rd_write_en   <= w_out_v && w_out_ent.rd_en;
            r_wb_cpsr_write_en <= w_out_v && w_out_ent.cpsr_en;
            r_wb_branch_en     <= w_out_v && w_out_ent.rd_en && (w_out_ent.rd_num == REG_PC);
            if (w_out_v && w_out_ent.rd_en) begin
                r_wb_rd_num <= w_out_ent.rd_num;
                r_wb_rd_in  <= w_out_ent.data;
            end
            if (w_out_v && w_out_ent.cpsr_en) begin
                r_wb_cpsr_in <= w_out_ent.cpsr;
            end
            r_busy_mask <= w_busy_next;
        end
    end

    assign exe_ready        = w_ready;
    assign mem_ready        = w_ready;
    assign wb_rd_num        = r_wb_rd_num;
    assign wb_rd_write_en   = r_wb_rd_write_en;
    assign wb_rd_in         = r_wb_rd_in;
    assign wb_cpsr_write_en = r_wb_cpsr_write_en;
    assign wb_cpsr_in       = r_wb_cpsr_in;
    assign wb_branch_en     = r_wb_branch_en;
    assign wb_branch_target = r_wb_rd_in;
    assign busy_mask        = r_busy_mask;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Bench for wb_retire_unit: directed vector table, multi-cycle sequences and
// random traffic against an in-order queue reference model.
module tb_wb_retire_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_valid, exe_ready, exe_rd_en, exe_cpsr_en;
    logic [3:0]  exe_rd_num;
    logic [31:0] exe_result, exe_cpsr;
    logic        mem_valid, mem_ready;
    logic [3:0]  mem_rd_num;
    logic [31:0] mem_data;
    logic [3:0]  wb_rd_num;
    logic        wb_rd_write_en, wb_cpsr_write_en, wb_branch_en;
    logic [31:0] wb_rd_in, wb_cpsr_in, wb_branch_target;
    logic [15:0] busy_mask;

    always #5 clk = ~clk;

    wb_retire_unit #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .exe_valid        (exe_valid),
        .exe_ready        (exe_ready),
        .exe_rd_num       (exe_rd_num),
        .exe_rd_en        (exe_rd_en),
        .exe_result       (exe_result),
        .exe_cpsr_en      (exe_cpsr_en),
        .exe_cpsr         (exe_cpsr),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_rd_num       (mem_rd_num),
        .mem_data         (mem_data),
        .wb_rd_num        (wb_rd_num),
        .wb_rd_write_en   (wb_rd_write_en),
        .wb_rd_in         (wb_rd_in),
        .wb_cpsr_write_en (wb_cpsr_write_en),
        .wb_cpsr_in       (wb_cpsr_in),
        .wb_branch_en     (wb_branch_en),
        .wb_branch_target (wb_branch_target),
        .busy_mask        (busy_mask)
    );

    // Reference model: a plain ordered list of entries awaiting retirement.
    typedef struct {
        bit [3:0]  rd;
        bit        rd_en;
        bit [31:0] data;
        bit        cpsr_en;
        bit [31:0] cpsr;
    } m_ent_t;

    typedef struct {
        bit        rst_n;
        bit        mv;  bit [3:0] mrd; bit [31:0] mdata;
        bit        ev;  bit [3:0] erd; bit een; bit [31:0] edata; bit ecen; bit [31:0] ecpsr;
        bit        x_we; bit [3:0] x_rd; bit [31:0] x_data;
        bit        x_cwe; bit [31:0] x_cpsr; bit x_br; bit [15:0] x_busy;
    } vec_t;

    m_ent_t      mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] ret_log[$];
    int          checks   = 0;
    int          failures = 0;
    bit          e_we, e_cwe, e_br;
    bit [3:0]    e_rd;
    bit [31:0]   e_data, e_cpsr;
    bit [15:0]   e_busy;
    logic        g_rdy;
    vec_t        vt[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle();
        mem_valid = 0; mem_rd_num = 0; mem_data = 0;
        exe_valid = 0; exe_rd_num = 0; exe_rd_en = 0; exe_result = 0;
        exe_cpsr_en = 0; exe_cpsr = 0;
    endtask

    // One clock: check readies before the edge, advance the model, check outputs after.
    task automatic step();
        bit     rdy;
        bit     ov;
        m_ent_t o;
        #1;
        rdy   = reset && (mq.size() <= int'(DEPTH) - 2);
        g_rdy = exe_ready;
        chk("exe_ready", 32'(exe_ready), 32'(rdy));
        chk("mem_ready", 32'(mem_ready), 32'(rdy));
        if (!reset) begin
            mq.delete();
            e_we = 0; e_rd = 0; e_data = 0; e_cwe = 0; e_cpsr = 0; e_br = 0; e_busy = 0;
        end else begin
            if (mem_valid && rdy) begin
                mq.push_back('{mem_rd_num, 1'b1, mem_data, 1'b0, 32'h0});
                acc_log.push_back(mem_data);
            end
            if (exe_valid && rdy) begin
                mq.push_back('{exe_rd_num, exe_rd_en, exe_result, exe_cpsr_en, exe_cpsr});
                acc_log.push_back(exe_result);
            end
            ov = (mq.size() > 0);
            o  = '{default: 0};
            if (ov) o = mq.pop_front();
            e_we  = ov && o.rd_en;
            e_cwe = ov && o.cpsr_en;
            if (e_we) begin
                e_rd   = o.rd;
                e_data = o.data;
            end
            if (e_cwe) e_cpsr = o.cpsr;
            e_br   = e_we && (o.rd == 4'd15);
            e_busy = 0;
            foreach (mq[i]) if (mq[i].rd_en) e_busy[mq[i].rd] = 1'b1;
            if (e_we) e_busy[e_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("wb_rd_write_en", 32'(wb_rd_write_en), 32'(e_we));
        chk("wb_cpsr_write_en", 32'(wb_cpsr_write_en), 32'(e_cwe));
        chk("wb_branch_en", 32'(wb_branch_en), 32'(e_br));
        chk("busy_mask", 32'(busy_mask), 32'(e_busy));
        if (e_we) begin
            chk("wb_rd_num", 32'(wb_rd_num), 32'(e_rd));
            chk("wb_rd_in", wb_rd_in, e_data);
        end
        if (e_cwe) chk("wb_cpsr_in", wb_cpsr_in, e_cpsr);
        if (e_br)  chk("wb_branch_target", wb_branch_target, e_data);
        if (wb_rd_write_en === 1'b1) ret_log.push_back(wb_rd_in);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mk, ek;
        bit low_seen;

        // rst_n | mem v,rd,data | exe v,rd,en,data,cpsr_en,cpsr | exp we,rd,data,cwe,cpsr,br,busy
        vt[0] = '{0, 0, 0, 0,     0, 0,  0, 0,       0, 0,            0, 0,  0,       0, 0,            0, 'h0000};
        vt[1] = '{1, 0, 0, 0,     1, 3,  1, 'h1234,  0, 0,            1, 3,  'h1234,  0, 0,            0, 'h0008};
        vt[2] = '{1, 0, 0, 0,     0, 0,  0, 0,       0, 0,            0, 0,  0,       0, 0,            0, 'h0000};
        vt[3] = '{1, 1, 1, 'hAA,  1, 2,  1, 'hBB,    0, 0,            1, 1,  'hAA,    0, 0,            0, 'h0006};
        vt[4] = '{1, 0, 0, 0,     0, 0,  0, 0,       0, 0,            1, 2,  'hBB,    0, 0,            0, 'h0004};
        vt[5] = '{1, 0, 0, 0,     0, 0,  0, 0,       0, 0,            0, 0,  0,       0, 0,            0, 'h0000};
        vt[6] = '{1, 0, 0, 0,     1, 15, 1, 'h40,    0, 0,            1, 15, 'h40,    0, 0,            1, 'h8000};
        vt[7] = '{1, 0, 0, 0,     1, 0,  0, 0,       1, 'h80000000,   0, 0,  0,       1, 'h80000000,   0, 'h0000};
        vt[8] = '{1, 0, 0, 0,     0, 0,  0, 0,       0, 0,            0, 0,  0,       0, 0,            0, 'h0000};

        reset = 1'b0;
        idle();

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            reset = vt[i].rst_n;
            mem_valid = vt[i].mv; mem_rd_num = vt[i].mrd; mem_data = vt[i].mdata;
            exe_valid = vt[i].ev; exe_rd_num = vt[i].erd; exe_rd_en = vt[i].een;
            exe_result = vt[i].edata; exe_cpsr_en = vt[i].ecen; exe_cpsr = vt[i].ecpsr;
            step();
            chk("vec we", 32'(wb_rd_write_en), 32'(vt[i].x_we));
            chk("vec cwe", 32'(wb_cpsr_write_en), 32'(vt[i].x_cwe));
            chk("vec branch", 32'(wb_branch_en), 32'(vt[i].x_br));
            chk("vec busy", 32'(busy_mask), 32'(vt[i].x_busy));
            if (vt[i].x_we) begin
                chk("vec rd_num", 32'(wb_rd_num), 32'(vt[i].x_rd));
                chk("vec rd_in", wb_rd_in, vt[i].x_data);
            end
            if (vt[i].x_cwe) chk("vec cpsr_in", wb_cpsr_in, vt[i].x_cpsr);
            if (vt[i].x_br)  chk("vec target", wb_branch_target, vt[i].x_data);
        end
        idle();

        // Both sources saturated for 8 cycles, then drain; retire order must match accept order.
        acc_log.delete();
        ret_log.delete();
        mk = 0; ek = 0; low_seen = 0;
        for (int c = 0; c < 8; c++) begin
            mem_valid = 1; mem_rd_num = 4'(mk % 8);     mem_data   = 32'hA000_0000 + 32'(mk);
            exe_valid = 1; exe_rd_num = 4'(8 + ek % 7); exe_result = 32'hB000_0000 + 32'(ek);
            exe_rd_en = 1; exe_cpsr_en = 0;
            step();
            if (g_rdy === 1'b1) begin
                mk++;
                ek++;
            end else begin
                low_seen = 1;
            end
        end
        idle();
        for (int c = 0; c < 12; c++) step();
        chk("seqA ready dropped", 32'(low_seen), 32'd1);
        chk("seqA retired count", 32'(ret_log.size()), 32'(acc_log.size()));
        for (int i = 0; i < acc_log.size() && i < ret_log.size(); i++)
            chk("seqA retire order", ret_log[i], acc_log[i]);

        // Fill to three queued entries, then reset for one edge.
        for (int c = 0; c < 3; c++) begin
            mem_valid = 1; mem_rd_num = 4'(c + 1); mem_data = 32'hC000_0000 + 32'(c);
            exe_valid = 1; exe_rd_num = 4'(c + 5); exe_rd_en = 1;
            exe_result = 32'hD000_0000 + 32'(c);
            step();
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle();
        chk("rst we", 32'(wb_rd_write_en), 32'd0);
        chk("rst cwe", 32'(wb_cpsr_write_en), 32'd0);
        chk("rst branch", 32'(wb_branch_en), 32'd0);
        chk("rst busy", 32'(busy_mask), 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            if (c == 0) chk("rst ready after", 32'(g_rdy), 32'd1);
            chk("rst no stale write", 32'(wb_rd_write_en), 32'd0);
        end

        // Random traffic with occasional resets.
        for (int c = 0; c < 500; c++) begin
            reset       = ($urandom_range(0, 39) != 0);
            mem_valid   = ($urandom_range(0, 9) < 6);
            mem_rd_num  = 4'($urandom);
            mem_data    = $urandom;
            exe_valid   = ($urandom_range(0, 9) < 6);
            exe_rd_num  = 4'($urandom);
            exe_rd_en   = ($urandom_range(0, 3) != 0);
            exe_result  = $urandom;
            exe_cpsr_en = ($urandom_range(0, 3) == 0);
            exe_cpsr    = $urandom;
            step();
        end
        reset = 1'b1;
        idle();
        for (int c = 0; c < 6; c++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_retire_unit.md
# wb_retire_unit

Writeback retire unit between the EXE/MEM result producers and the register file write port. It accepts ALU results from EXE and load data from MEM through valid/ready handshakes and buffers them in a small in-order queue. It drains one retirement per cycle onto the register file's `wb_rd_*` and `wb_cpsr_*` inputs. It also publishes a pending-write busy mask for hazard checks and pulses a redirect when r15 (PC) is written.

## Interface
- `DEPTH`, 4: queue entries, excluding the output register; minimum 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low.
- `exe_valid` in 1: EXE offers a result.
- `exe_ready` out 1: EXE result accepted this cycle when high together with `exe_valid`.
- `exe_rd_num` in 4: EXE destination register.
- `exe_rd_en` in 1: EXE result writes `exe_rd_num`.
- `exe_result` in 32: EXE data.
- `exe_cpsr_en` in 1: EXE updates CPSR.
- `exe_cpsr` in 32: new CPSR value.
- `mem_valid` in 1: MEM offers load data.
- `mem_ready` out 1: MEM handshake.
- `mem_rd_num` in 4: MEM destination register.
- `mem_data` in 32: MEM load data. MEM entries always write rd and never write CPSR.
- `wb_rd_num` out 4: register file write address.
- `wb_rd_write_en` out 1: register file write enable.
- `wb_rd_in` out 32: register file write data.
- `wb_cpsr_write_en` out 1: CPSR write enable.
- `wb_cpsr_in` out 32: CPSR write data.
- `wb_branch_en` out 1: one-cycle pulse when the retiring entry writes r15.
- `wb_branch_target` out 32: equals `wb_rd_in` while `wb_branch_en` is high.
- `busy_mask` out 16: bit i set while any queued entry or the output register holds a write to register i.

## Operation
- Entry fields: `rd_num`, `rd_en`, `data`, `cpsr_en`, `cpsr`.
- An entry is accepted on a cycle where `valid && ready`.
- Both sources may be accepted in the same cycle. MEM is ordered before EXE.
- Ready: `mem_ready = exe_ready = (count <= DEPTH-2)`. This guarantees room for two pushes. Both are 0 while `reset` is low.
- Output register is updated every cycle. Source priority:
  1. Queue head, if `count > 0`.
  2. Otherwise the first accepted entry this cycle (bypass).
  3. Otherwise a bubble: all enables 0. Data outputs hold their last value.
- Entries accepted this cycle but not taken by the output register are pushed in order, MEM first.
- `count` update: `count_next = count + pushes − (count > 0 ? 1 : 0)`. The value never exceeds `DEPTH`.
- `wb_branch_en = wb_rd_write_en && wb_rd_num == 15`. No flush: younger entries retire normally.
- An entry with `rd_en = 0` and `cpsr_en = 0` still occupies a retire slot and drives a bubble.
- `busy_mask` is the OR of one-hot(`rd_num`) gated by `rd_en` over all valid queue entries plus the output register. It is registered, so it reflects state after the edge.

## Timing
- Reset (reset low at an edge): `count = 0`. All `wb_*` outputs, `busy_mask` and `wb_branch_en` are 0. Queue contents are don't-care.
- Latency: an entry accepted at edge N with an empty queue appears on the `wb_*` outputs after edge N (visible in cycle N+1). The register file captures it at edge N+1.
- Throughput: one retirement per cycle. Two sources at 100% valid fill the queue by one entry per cycle until ready drops.
- Full: at `count = DEPTH-1` or `DEPTH`, both readies are low. The queue still drains one per cycle.
- Reset mid-operation: queued and in-flight entries are discarded. No write is issued in the cycle after reset.
- Simultaneous push and pop at `count = DEPTH` cannot occur, because ready is low.

## Structure
- Shared constants in the CPU package/defines: `REG_NUM_W = 4`, `DATA_W = 32`, `REG_PC = 4'd15`, and the entry field layout (packed width 70).
- Sub-module `wb_fifo`: circular buffer with `DEPTH` entries, 2-push/1-pop, head/tail pointers with wrap-around, and a per-entry `rd_en`/`rd_num` fan-out for the busy mask.
- The top level holds the accept logic, the output register, the branch pulse and the busy-mask OR.

## Test plan
- **Reset, then single EXE push** (`rd = 3`, data `0x1234`): `wb_rd_write_en = 1`, `wb_rd_num = 3`, `wb_rd_in = 0x1234` exactly one cycle after acceptance. `busy_mask = 0x0008` for that cycle, then 0.
- **Simultaneous MEM (`rd = 1`, `0xAA`) and EXE (`rd = 2`, `0xBB`)**: `rd = 1` retires in cycle +1 and `rd = 2` in cycle +2. `busy_mask = 0x0006`, then `0x0004`, then 0.
- **Both sources valid for 8 cycles, `DEPTH = 4`**: readies drop once `count = 3`. All accepted entries retire in MEM/EXE interleaved order, with none lost or duplicated.
- **EXE writes `rd = 15`, data `0x40`**: `wb_branch_en` pulses for one cycle with `wb_branch_target = 0x40`. An EXE entry with `cpsr_en` and `0x80000000` gives `wb_cpsr_write_en = 1`, `wb_cpsr_in = 0x80000000`.
- **Fill the queue to 3, then assert `reset` low for one edge**: the next cycle has all `wb_*` enables at 0, `busy_mask = 0` and readies at 1. No stale write follows.
